cap_err_chk: RTL and testbench
==============================

Name: cap_err_chk

Overview:
- Testbench-side checker directly downstream of the CHERI load/store/CJALR capability-error injector.
- Consumes the injector's per-instruction injection record plus core exception/retire observations.
- Confirms each injected error yields the correct trap within a bounded window and keeps pass/fail statistics.
- Cycle-accurate synthesizable-style RTL, instantiated in the cheriot tb next to the injector.

Parameters:
TIMEOUT, 64, max cycles from injection to resolution before a timeout failure; range 2..1023
CNT_W, 16, width of statistic counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inj_valid  in  1  1-cycle pulse: error injected into instruction at inj_pc
inj_type  in  3  0 tag, 1 seal, 2 ld-perm, 3 sd-perm, 4 mc-perm, 5 bound, 6 align, 7 none/skip
inj_skip  in  1  injector gave up (its flag[7]); record ignored
inj_pc  in  32  PC of injected instruction
exc_valid  in  1  core takes exception this cycle
exc_cheri  in  1  exception is CHERI class
exc_cause  in  5  CHERI cause code (valid when exc_cheri)
exc_pc  in  32  faulting PC
ret_valid  in  1  instruction retired without exception
ret_pc  in  32  PC of retired instruction
err_failed  in  1  injector reports LSU request issued despite active error
chk_busy  out  1  check pending
chk_fail  out  1  1-cycle pulse on any failure
chk_fail_code  out  3  code of last failure, held until next failure
inj_cnt  out  CNT_W  accepted injections
pass_cnt  out  CNT_W  passes
fail_cnt  out  CNT_W  failures
log_rd  in  1  pop one failure-log entry (optional feature)
log_valid  out  1  failure log non-empty (optional feature)
log_pc  out  32  head-entry PC (optional feature)
log_code  out  3  head-entry fail code (optional feature)

Behaviour:
- Reset: all outputs 0; FSM IDLE; timer 0; log empty.
- Expected cause: tag 0x02, seal 0x03, ld-perm 0x12, sd-perm 0x13, mc-perm 0x15, bound 0x01.
- Align expects exc_valid & ~exc_cheri with any cause.
- inj_type 7 or inj_skip=1: record dropped; not counted.
- Fail codes: 1 wrong cause/class, 2 escaped (ret_pc==pending PC), 3 leaked LSU request (err_failed), 4 timeout, 5 overlap.
- FSM IDLE: on accepted inj_valid, latch type/PC, timer=0, inj_cnt++, go WAIT.
  - exc/ret/err_failed in IDLE are ignored; they belong to earlier instructions.
- FSM WAIT: timer increments each cycle. Resolution priority, highest first:
  - err_failed -> fail 3.
  - exc_valid & exc_pc==PC -> pass if class/cause match, else fail 1.
  - ret_valid & ret_pc==PC -> fail 2.
  - timer==TIMEOUT-1 with no event -> fail 4.
  - After resolving, return to IDLE.
- exc_valid with PC mismatch is ignored (async/interrupt traps).
- inj_valid in WAIT, same cycle as resolution: resolve pending first, then latch new record; stay WAIT with timer=0.
- inj_valid in WAIT, no resolution: new record dropped; fail 5 pulsed; fail_cnt++; pending check continues.
- Pass/fail counters and the fail pulse update one cycle after the deciding event, i.e. registered.
- Counters saturate at all-ones; no wrap.
- chk_busy = (state==WAIT).
- Reset mid-WAIT: immediate return to IDLE; counters cleared.

Optional Feature:
CAP_ERR_CHK_LOG_EN:
- Defined: 4-entry failure log FIFO of {PC, code}; written on every chk_fail.
  - When full, oldest entry is overwritten.
  - log_rd pops when log_valid; log_rd on empty is ignored.
  - Simultaneous write and pop when full: pop head, then append.
- Undefined: no storage; log_valid, log_pc, log_code tied 0; log_rd ignored.

Test Plan:
- inj_type=0, PC 0x8000_0100; exc_cheri cause 0x02 at that PC 5 cycles later -> pass_cnt=1, fail_cnt=0, chk_busy low next cycle.
- inj_type=3; exc cause 0x12 at matching PC -> chk_fail pulse, code 1, fail_cnt=1.
- inj_type=5; ret_valid at matching PC -> code 2; then separately err_failed in WAIT -> code 3.
- TIMEOUT=8, inject with no response -> chk_fail exactly 8 cycles after inj_valid, code 4.
- Second inj_valid 2 cycles into WAIT -> code 5, first check still passes on its exception; inj_valid same cycle as passing exc -> both accepted, inj_cnt=2.
- With CAP_ERR_CHK_LOG_EN: 5 timeouts -> log holds failures 2..5; four log_rd -> log_valid drops; inj_skip=1 pulse -> inj_cnt unchanged.

Source files
------------

// File: rtl/cap_err_chk.sv
// Confirms each injected CHERI capability error ends in the expected trap within TIMEOUT cycles.
// Define CAP_ERR_CHK_LOG_EN to add a 4-entry failure log; the default build ties the log outputs to 0.
module cap_err_chk #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inj_valid,
  input  logic [2:0]       inj_type,
  input  logic             inj_skip,
  input  logic [31:0]      inj_pc,
  input  logic             exc_valid,
  input  logic             exc_cheri,
  input  logic [4:0]       exc_cause,
  input  logic [31:0]      exc_pc,
  input  logic             ret_valid,
  input  logic [31:0]      ret_pc,
  input  logic             err_failed,
  output logic             chk_busy,
  output logic             chk_fail,
  output logic [2:0]       chk_fail_code,
  output logic [CNT_W-1:0] inj_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  input  logic             log_rd,
  output logic             log_valid,
  output logic [31:0]      log_pc,
  output logic [2:0]       log_code
);

  localparam int TMR_W = 10;

  // state  | meaning
  // S_IDLE | no check pending;  S_WAIT | awaiting the trap for pc_q
  typedef enum logic {S_IDLE, S_WAIT} state_e;

  function automatic logic [4:0] exp_cause(input logic [2:0] t);
    case (t)
      3'd0:    return 5'h02;
      3'd1:    return 5'h03;
      3'd2:    return 5'h12;
      3'd3:    return 5'h13;
      3'd4:    return 5'h15;
      3'd5:    return 5'h01;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q;
  logic [2:0]       type_q;
  logic [31:0]      pc_q;
  logic [TMR_W-1:0] timer_q;
  logic             fail_q;
  logic [2:0]       code_q;
  logic [CNT_W-1:0] inj_cnt_q, pass_cnt_q, fail_cnt_q;

  logic       inj_acc, exc_ok, resolved, res_pass, res_fail, overlap, fail_now, latch;
  logic [2:0] res_code, fail_code_d;

  assign inj_acc = inj_valid & ~inj_skip & (inj_type != 3'd7);
  // Align faults are non-CHERI exceptions, so only the class is checked.
  assign exc_ok  = (type_q == 3'd6) ? ~exc_cheri
                                    : (exc_cheri & (exc_cause == exp_cause(type_q)));

  always_comb begin
    resolved = 1'b0;
    res_pass = 1'b0;
    res_fail = 1'b0;
    res_code = 3'd0;
    if (state_q == S_WAIT) begin
      if (err_failed) begin
        resolved = 1'b1;
        res_fail = 1'b1;
        res_code = 3'd3;
      end else if (exc_valid && exc_pc == pc_q) begin
        resolved = 1'b1;
        res_pass = exc_ok;
        res_fail = ~exc_ok;
        res_code = 3'd1;
      end else if (ret_valid && ret_pc == pc_q) begin
        resolved = 1'b1;
        res_fail = 1'b1;
        res_code = 3'd2;
      end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
        resolved = 1'b1;
        res_fail = 1'b1;
        res_code = 3'd4;
      end
    end
  end

  assign overlap     = (state_q == S_WAIT) & inj_acc & ~resolved;
  assign fail_now    = res_fail | overlap;
  assign fail_code_d = overlap ? 3'd5 : res_code;
  assign latch       = inj_acc & ((state_q == S_IDLE) | resolved);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      type_q     <= 3'd0;
      pc_q       <= 32'd0;
      timer_q    <= '0;
      fail_q     <= 1'b0;
      code_q     <= 3'd0;
      inj_cnt_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      fail_q <= fail_now;
      if (fail_now) begin
        code_q     <= fail_code_d;
        fail_cnt_q <= sat_inc(fail_cnt_q);
      end
      if (res_pass) pass_cnt_q <= sat_inc(pass_cnt_q);
      if (latch) begin
        state_q   <= S_WAIT;
        type_q    <= inj_type;
        pc_q      <= inj_pc;
        timer_q   <= '0;
        inj_cnt_q <= sat_inc(inj_cnt_q);
      end else if (resolved) begin
        state_q <= S_IDLE;
        timer_q <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + TMR_W'(1);
      end
    end
  end

  assign chk_busy      = (state_q == S_WAIT);
  assign chk_fail      = fail_q;
  assign chk_fail_code = code_q;
  assign inj_cnt       = inj_cnt_q;
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;

`ifdef CAP_ERR_CHK_LOG_EN
  logic [31:0] lpc_q   [4];
  logic [2:0]  lcode_q [4];
  logic [1:0]  rd_q, wr_q;
  logic [2:0]  lcnt_q;
  logic [31:0] fail_pc;
  logic        log_pop, log_adv;

  // An overlap failure is logged against the dropped record, not the pending one.
  assign fail_pc = overlap ? inj_pc : pc_q;
  assign log_pop = log_rd & (lcnt_q != 3'd0);
  assign log_adv = log_pop | (fail_now & (lcnt_q == 3'd4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        lpc_q[i]   <= 32'd0;
        lcode_q[i] <= 3'd0;
      end
      rd_q   <= 2'd0;
      wr_q   <= 2'd0;
      lcnt_q <= 3'd0;
    end else begin
      if (fail_now) begin
        lpc_q[wr_q]   <= fail_pc;
        lcode_q[wr_q] <= fail_code_d;
        wr_q          <= wr_q + 2'd1;
      end
      if (log_adv) rd_q <= rd_q + 2'd1;
      lcnt_q <= lcnt_q + 3'(fail_now) - 3'(log_adv);
    end
  end

  assign log_valid = (lcnt_q != 3'd0);
  assign log_pc    = lpc_q[rd_q];
  assign log_code  = lcode_q[rd_q];
`else
  logic unused_log_rd;
  assign unused_log_rd = log_rd;
  assign log_valid     = 1'b0;
  assign log_pc        = 32'd0;
  assign log_code      = 3'd0;
`endif

endmodule

// File: tb/tb_cap_err_chk.sv
// Randomized bench for cap_err_chk against a cycle-level reference model.
// Build with CAP_ERR_CHK_LOG_EN defined to also check the failure log.
module tb_cap_err_chk;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk, rst_n;
  logic iv, is, ev, ec, rv, ef, lr;
  logic [2:0]  it;
  logic [4:0]  cause;
  logic [31:0] ipc, epc, rpc;
  logic chk_busy, chk_fail, log_valid;
  logic [2:0] chk_fail_code, log_code;
  logic [CNT_W-1:0] inj_cnt, pass_cnt, fail_cnt;
  logic [31:0] log_pc;

  cap_err_chk #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(iv), .inj_type(it), .inj_skip(is), .inj_pc(ipc),
    .exc_valid(ev), .exc_cheri(ec), .exc_cause(cause), .exc_pc(epc),
    .ret_valid(rv), .ret_pc(rpc), .err_failed(ef),
    .chk_busy(chk_busy), .chk_fail(chk_fail), .chk_fail_code(chk_fail_code),
    .inj_cnt(inj_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .log_rd(lr), .log_valid(log_valid), .log_pc(log_pc), .log_code(log_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending record, identified by the cycle it was accepted on.
  int          cyc = 0;
  bit          m_busy;
  logic [2:0]  m_type;
  logic [31:0] m_pc;
  int          m_inj_cyc;
  int          m_inj, m_pass, m_fail;
  bit          m_failp;
  logic [2:0]  m_code;
  logic [34:0] log_q[$];

  function automatic logic [4:0] want_cause(input logic [2:0] t);
    case (t)
      3'd0: return 5'h02;
      3'd1: return 5'h03;
      3'd2: return 5'h12;
      3'd3: return 5'h13;
      3'd4: return 5'h15;
      3'd5: return 5'h01;
      default: return 5'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_type = 0; m_pc = 0; m_inj_cyc = 0;
    m_inj = 0; m_pass = 0; m_fail = 0; m_failp = 0; m_code = 0;
    log_q.delete();
  endtask

  task automatic model_step();
    bit acc, resolved, fp, ps, good;
    logic [2:0]  fcode;
    logic [31:0] fpc;
    cyc++;
    acc = iv && !is && (it != 3'd7);
    resolved = 0; fp = 0; ps = 0; fcode = 0; fpc = m_pc;
    if (m_busy) begin
      if (ef) begin
        resolved = 1; fp = 1; fcode = 3;
      end else if (ev && epc == m_pc) begin
        resolved = 1;
        if (m_type == 3'd6) good = !ec;
        else good = ec && (cause == want_cause(m_type));
        if (good) ps = 1;
        else begin fp = 1; fcode = 1; end
      end else if (rv && rpc == m_pc) begin
        resolved = 1; fp = 1; fcode = 2;
      end else if (cyc - m_inj_cyc == TIMEOUT) begin
        resolved = 1; fp = 1; fcode = 4;
      end
    end
    if (m_busy && acc && !resolved) begin
      fp = 1; fcode = 5; fpc = ipc;
    end
    if (lr && log_q.size() > 0) void'(log_q.pop_front());
    if (fp) log_q.push_back({fpc, fcode});
    if (log_q.size() > 4) void'(log_q.pop_front());
    m_failp = fp;
    if (fp) begin
      m_code = fcode;
      if (m_fail < MAXC) m_fail++;
    end
    if (ps && m_pass < MAXC) m_pass++;
    if (acc && (!m_busy || resolved)) begin
      m_busy = 1; m_type = it; m_pc = ipc; m_inj_cyc = cyc;
      if (m_inj < MAXC) m_inj++;
    end else if (resolved) begin
      m_busy = 0;
    end
  endtask

  task automatic compare_all(input string ph);
    chk_eq({ph, "_busy"}, 32'(chk_busy), 32'(m_busy));
    chk_eq({ph, "_fail"}, 32'(chk_fail), 32'(m_failp));
    chk_eq({ph, "_code"}, 32'(chk_fail_code), 32'(m_code));
    chk_eq({ph, "_inj_cnt"}, 32'(inj_cnt), 32'(m_inj));
    chk_eq({ph, "_pass_cnt"}, 32'(pass_cnt), 32'(m_pass));
    chk_eq({ph, "_fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
`ifdef CAP_ERR_CHK_LOG_EN
    chk_eq({ph, "_log_valid"}, 32'(log_valid), 32'(log_q.size() != 0));
    if (log_q.size() != 0) begin
      chk_eq({ph, "_log_pc"}, log_pc, log_q[0][34:3]);
      chk_eq({ph, "_log_code"}, 32'(log_code), 32'(log_q[0][2:0]));
    end
`else
    chk_eq({ph, "_log_valid"}, 32'(log_valid), 32'd0);
    chk_eq({ph, "_log_pc"}, log_pc, 32'd0);
    chk_eq({ph, "_log_code"}, 32'(log_code), 32'd0);
`endif
  endtask

  task automatic clear_in();
    iv = 0; it = 0; is = 0; ipc = 0; ev = 0; ec = 0; cause = 0; epc = 0;
    rv = 0; rpc = 0; ef = 0; lr = 0;
  endtask

  string phase = "init";

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all(phase);
    clear_in();
  endtask

  task automatic inject(input logic [2:0] t, input logic [31:0] pc);
    iv = 1; it = t; ipc = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] pool_pc();
    return 32'h8000_0000 + ($urandom_range(0, 7) << 2);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    model_reset();
    rst_n = 0;
    #13;
    phase = "reset";
    compare_all(phase);
    #10 rst_n = 1;
    idle(2);

    // Correct tag trap five cycles after injection.
    phase = "tag_pass";
    inject(3'd0, 32'h8000_0100); tick();
    idle(4);
    ev = 1; ec = 1; cause = 5'h02; epc = 32'h8000_0100; tick();
    idle(2);

    // sd-perm expects 0x13; 0x12 is the wrong cause.
    phase = "wrong_cause";
    inject(3'd3, 32'h8000_0200); tick();
    idle(2);
    ev = 1; ec = 1; cause = 5'h12; epc = 32'h8000_0200; tick();
    idle(1);

    // Align accepts a non-CHERI exception, rejects a CHERI one.
    phase = "align";
    inject(3'd6, 32'h8000_0240); tick();
    ev = 1; ec = 0; cause = 5'h1f; epc = 32'h8000_0240; tick();
    inject(3'd6, 32'h8000_0244); tick();
    ev = 1; ec = 1; cause = 5'h00; epc = 32'h8000_0244; tick();

    phase = "escape";
    inject(3'd5, 32'h8000_0300); tick();
    ev = 1; ec = 1; cause = 5'h01; epc = 32'h8000_0304; tick();
    rv = 1; rpc = 32'h8000_0300; tick();
    idle(1);

    phase = "leak";
    inject(3'd1, 32'h8000_0400); tick();
    idle(1);
    ef = 1; ev = 1; ec = 1; cause = 5'h03; epc = 32'h8000_0400; tick();
    idle(1);

    phase = "idle_ignore";
    ef = 1; ev = 1; rv = 1; epc = 32'h8000_0400; rpc = 32'h8000_0400; tick();
    is = 1; inject(3'd2, 32'h8000_0440); tick();
    inject(3'd7, 32'h8000_0444); tick();

    phase = "timeout";
    inject(3'd4, 32'h8000_0500); tick();
    idle(TIMEOUT + 2);

    // Overlap then pass, then new injection in the same cycle as a passing trap.
    phase = "overlap";
    inject(3'd2, 32'h8000_0600); tick();
    idle(1);
    inject(3'd0, 32'h8000_0700); tick();
    ev = 1; ec = 1; cause = 5'h12; epc = 32'h8000_0600; tick();
    inject(3'd2, 32'h8000_0800); tick();
    inject(3'd5, 32'h8000_0900);
    ev = 1; ec = 1; cause = 5'h12; epc = 32'h8000_0800; tick();
    ev = 1; ec = 1; cause = 5'h01; epc = 32'h8000_0900; tick();

    phase = "log_fill";
    for (int k = 0; k < 5; k++) begin
      inject(3'd0, 32'h8000_1000 + 32'(k * 16)); tick();
      idle(TIMEOUT);
    end
    phase = "log_drain";
    for (int k = 0; k < 5; k++) begin
      lr = 1; tick();
    end

    phase = "rst_mid";
    inject(3'd1, 32'h8000_2000); tick();
    idle(2);
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all(phase);
    #1 rst_n = 1;
    idle(2);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      iv  = ($urandom_range(0, 6) == 0);
      it  = 3'($urandom_range(0, 7));
      is  = ($urandom_range(0, 5) == 0);
      ipc = pool_pc();
      ev  = ($urandom_range(0, 7) == 0);
      epc = (m_busy && $urandom_range(0, 2) != 0) ? m_pc : pool_pc();
      ec  = ($urandom_range(0, 3) != 0);
      cause = (m_busy && $urandom_range(0, 1) == 1) ? want_cause(m_type)
                                                   : 5'($urandom_range(0, 31));
      rv  = ($urandom_range(0, 9) == 0);
      rpc = (m_busy && $urandom_range(0, 1) == 1) ? m_pc : pool_pc();
      ef  = ($urandom_range(0, 39) == 0);
      lr  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
